// File: rtl/clk_rst_pkg.sv
// Shared types and sizing helpers for the AWG reset sequencer.
package clk_rst_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_MMCM = 3'd1,
    HOLD      = 3'd2,
    DDR_CAL   = 3'd3,
    DAC_REL   = 3'd4,
    ADC_REL   = 3'd5,
    RUN       = 3'd6,
    FAULT     = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    DDR_TO    = 3'd1,
    DAC_TO    = 3'd2,
    ADC_TO    = 3'd3,
    MMCM_LOST = 3'd4,
    DAC_LOST  = 3'd5,
    GTH_LOST  = 3'd6,
    CAL_LOST  = 3'd7
  } fault_t;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 1000000;
  localparam int unsigned CNT_W_DEF          = $clog2(TIMEOUT_CYCLES_DEF);

  // The shared counter must reach both the timeout and the hold terminal counts.
  function automatic int unsigned cnt_width(input int unsigned timeout, input int unsigned hold);
    int unsigned m;
    m = (timeout > hold) ? timeout : hold;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/clk_presence_det.sv
// Clock presence detector: watches a divided toggle from a foreign clock
// domain and reports whether at least one edge arrived in the last window.
module clk_presence_det #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TOGGLE_WIN  = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic toggle_in,
  output logic dac_alive
);

  localparam int unsigned WIN_W = (TOGGLE_WIN < 2) ? 1 : $clog2(TOGGLE_WIN);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   tog_s;
  logic                   tog_d;
  logic                   edge_hit;
  logic                   seen;
  logic                   win_end;
  logic [WIN_W-1:0]       win_cnt;

  assign tog_s    = sync_q[SYNC_STAGES-1];
  assign edge_hit = tog_s ^ tog_d;
  assign win_end  = (win_cnt == WIN_W'(TOGGLE_WIN - 1));

  // Synchronize the toggle, detect edges and publish the per-window verdict.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q    <= '0;
      tog_d     <= 1'b0;
      seen      <= 1'b0;
      win_cnt   <= '0;
      dac_alive <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_in};
      tog_d  <= tog_s;
      if (win_end) begin
        win_cnt   <= '0;
        dac_alive <= seen | edge_hit;
        seen      <= 1'b0;
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
        seen    <= seen | edge_hit;
      end
    end
  end

endmodule

// File: rtl/clk_rst_seq.sv
// Power-up / recovery reset sequencer: releases DDR3, DAC and ADC resets in
// order once each upstream clock source is proven present, and re-sequences
// after any loss of a source.
module clk_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned HOLD_CYCLES    = 2000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TOGGLE_WIN     = 256
) (
  input  logic       DDR3_200M_CLK,
  input  logic       SYS_RST_N,
  input  logic       MMCM_LOCKED,
  input  logic       DDR3_CALIB_DONE,
  input  logic       DAC_CLK_TOGGLE,
  input  logic       GTH_QPLL_LOCK,
  input  logic       CLR_FAULT,
  output logic       DDR3_RST,
  output logic       DAC_RST_N,
  output logic       ADC_RST_N,
  output logic       SEQ_DONE,
  output logic [2:0] SEQ_STATE,
  output logic [2:0] FAULT_CODE,
  output logic [7:0] RETRY_CNT
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES, HOLD_CYCLES);

  logic [SYNC_STAGES-1:0] mmcm_q;
  logic [SYNC_STAGES-1:0] calib_q;
  logic [SYNC_STAGES-1:0] gth_q;
  logic                   mmcm_s;
  logic                   calib_s;
  logic                   gth_s;
  logic                   dac_alive;

  state_t             state;
  state_t             state_nxt;
  fault_t             fault_nxt;
  fault_t             fault_q;
  logic [CNT_W-1:0]   cnt;
  logic               hold_done;
  logic               timeout;

  assign mmcm_s    = mmcm_q[SYNC_STAGES-1];
  assign calib_s   = calib_q[SYNC_STAGES-1];
  assign gth_s     = gth_q[SYNC_STAGES-1];
  assign hold_done = (cnt == CNT_W'(HOLD_CYCLES - 1));
  assign timeout   = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  assign SEQ_STATE  = state;
  assign FAULT_CODE = fault_q;

  clk_presence_det #(
    .SYNC_STAGES (SYNC_STAGES),
    .TOGGLE_WIN  (TOGGLE_WIN)
  ) u_dac_det (
    .clk       (DDR3_200M_CLK),
    .rst_n     (SYS_RST_N),
    .toggle_in (DAC_CLK_TOGGLE),
    .dac_alive (dac_alive)
  );

  // Bring the level-type async status inputs into the sequencer domain.
  always_ff @(posedge DDR3_200M_CLK) begin
    if (!SYS_RST_N) begin
      mmcm_q  <= '0;
      calib_q <= '0;
      gth_q   <= '0;
    end else begin
      mmcm_q  <= {mmcm_q[SYNC_STAGES-2:0], MMCM_LOCKED};
      calib_q <= {calib_q[SYNC_STAGES-2:0], DDR3_CALIB_DONE};
      gth_q   <= {gth_q[SYNC_STAGES-2:0], GTH_QPLL_LOCK};
    end
  end

  // Next-state decision; any detected fault forces the FAULT state.
  always_comb begin
    state_nxt = state;
    fault_nxt = NONE;
    case (state)
      IDLE:      state_nxt = WAIT_MMCM;
      WAIT_MMCM: if (mmcm_s) state_nxt = HOLD;
      HOLD: begin
        if (!mmcm_s)        state_nxt = WAIT_MMCM;
        else if (hold_done) state_nxt = DDR_CAL;
      end
      DDR_CAL: begin
        if (!mmcm_s)       fault_nxt = MMCM_LOST;
        else if (calib_s)  state_nxt = DAC_REL;
        else if (timeout)  fault_nxt = DDR_TO;
      end
      DAC_REL: begin
        if (!mmcm_s)         fault_nxt = MMCM_LOST;
        else if (dac_alive)  state_nxt = ADC_REL;
        else if (timeout)    fault_nxt = DAC_TO;
      end
      ADC_REL: begin
        if (!mmcm_s)       fault_nxt = MMCM_LOST;
        else if (gth_s)    state_nxt = RUN;
        else if (timeout)  fault_nxt = ADC_TO;
      end
      RUN: begin
        if (!mmcm_s)          fault_nxt = MMCM_LOST;
        else if (!calib_s)    fault_nxt = CAL_LOST;
        else if (!dac_alive)  fault_nxt = DAC_LOST;
        else if (!gth_s)      fault_nxt = GTH_LOST;
      end
      FAULT:     if (hold_done) state_nxt = WAIT_MMCM;
      default:   state_nxt = IDLE;
    endcase
    if (fault_nxt != NONE) state_nxt = FAULT;
  end

  // State, shared counter, sticky fault code and retry counter.
  always_ff @(posedge DDR3_200M_CLK) begin
    if (!SYS_RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      fault_q   <= NONE;
      RETRY_CNT <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)  cnt <= '0;
      else if (cnt != '1)      cnt <= cnt + CNT_W'(1);
      // A new fault wins over a coincident clear.
      if (fault_nxt != NONE && (fault_q == NONE || CLR_FAULT)) fault_q <= fault_nxt;
      else if (CLR_FAULT)                                       fault_q <= NONE;
      if (state == FAULT && state_nxt == WAIT_MMCM && RETRY_CNT != 8'hFF)
        RETRY_CNT <= RETRY_CNT + 8'd1;
    end
  end

  // Reset outputs follow the registered state one cycle later, so release order is inherent.
  always_ff @(posedge DDR3_200M_CLK) begin
    if (!SYS_RST_N) begin
      DDR3_RST  <= 1'b1;
      DAC_RST_N <= 1'b0;
      ADC_RST_N <= 1'b0;
      SEQ_DONE  <= 1'b0;
    end else begin
      DDR3_RST  <= !(state inside {DDR_CAL, DAC_REL, ADC_REL, RUN});
      DAC_RST_N <= (state inside {ADC_REL, RUN});
      ADC_RST_N <= (state == RUN);
      SEQ_DONE  <= (state == RUN);
    end
  end

endmodule
